// File: rtl/bias_relu_serializer.sv
// Output stage after the matrix-vector multiplier: bias add with saturation, optional ReLU,
// then one element per beat over a valid/ready stream with a last flag.
module bias_relu_serializer #(
  parameter int unsigned M  = 5,
  parameter int unsigned DW = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:M-1][0:0][DW-1:0]   b_in,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [0:M-1][0:0][DW-1:0]   bias,
  input  logic                        relu_en,
  output logic [DW-1:0]               m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic                        busy
);

  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(M - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [M-1:0][DW-1:0] r_q;
  logic                capture;

  // Sign-extended DW+1 bit sum; overflow shows as the top two bits disagreeing.
  function automatic logic [DW-1:0] bias_act(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic relu);
    logic [DW:0]   sum;
    logic [DW-1:0] sat;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1]) begin
      sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat = sum[DW-1:0];
    end
    if (relu && sat[DW-1]) begin
      sat = '0;
    end
    return sat;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Result storage needs no reset: it is only observable while in StSend.
  always_ff @(posedge clk) begin
    if (reset && capture) begin
      for (int i = 0; i < M; i++) begin
        r_q[i] <= bias_act(b_in[i][0], bias[i][0], relu_en);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (b_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (m_tready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are gated by reset so they read 0 for the whole reset period.
  always_comb begin
    b_ready  = reset && (state_q == StIdle);
    m_tvalid = reset && (state_q == StSend);
    busy     = m_tvalid;
    m_tlast  = m_tvalid && (idx_q == LastIdx);
    m_tdata  = m_tvalid ? r_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_bias_relu_serializer.sv
// Directed bench for bias_relu_serializer: vector table plus backpressure, held-valid,
// mid-stream reset and single-row corner sequences.
module tb_bias_relu_serializer;

  logic                 clk;
  logic                 reset;
  logic [0:4][0:0][15:0] b_in;
  logic [0:4][0:0][15:0] bias;
  logic                 b_valid, b_ready, relu_en;
  logic [15:0]          m_tdata;
  logic                 m_tvalid, m_tready, m_tlast, busy;

  logic [0:0][0:0][15:0] b_in1;
  logic [0:0][0:0][15:0] bias1;
  logic                 b_valid1, b_ready1;
  logic [15:0]          m_tdata1;
  logic                 m_tvalid1, m_tlast1, busy1;
  logic                 m_tready1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int b[5];
    int bi[5];
    bit relu;
    int e[5];
  } vec_t;

  vec_t vecs[5];

  bias_relu_serializer #(.M(5), .DW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .b_in     (b_in),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .bias     (bias),
    .relu_en  (relu_en),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .busy     (busy)
  );

  bias_relu_serializer #(.M(1), .DW(16)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .b_in     (b_in1),
    .b_valid  (b_valid1),
    .b_ready  (b_ready1),
    .bias     (bias1),
    .relu_en  (1'b0),
    .m_tdata  (m_tdata1),
    .m_tvalid (m_tvalid1),
    .m_tready (m_tready1),
    .m_tlast  (m_tlast1),
    .busy     (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < 5; i++) begin
      b_in[i][0] = 16'(v.b[i]);
      bias[i][0] = 16'(v.bi[i]);
    end
    relu_en = v.relu;
  endtask

  task automatic expect_beat(input string tag, input int exp, input bit last);
    chk({tag, " tvalid"}, int'(m_tvalid), 1);
    chk({tag, " tdata"}, int'($signed(m_tdata)), exp);
    chk({tag, " tlast"}, int'(m_tlast), int'(last));
    chk({tag, " b_ready"}, int'(b_ready), 0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " idle b_ready"}, int'(b_ready), 1);
    chk({tag, " idle tvalid"}, int'(m_tvalid), 0);
    chk({tag, " idle busy"}, int'(busy), 0);
  endtask

  // One-cycle b_valid pulse, then M consecutive beats with tready high.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " ready before capture"}, int'(b_ready), 1);
    drive_vec(v);
    b_valid  = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_beat($sformatf("%s beat%0d", tag, k), v.e[k], k == 4);
      @(negedge clk);
    end
    expect_idle(tag);
  endtask

  initial begin
    vecs[0].b = '{10, -20, 30, -40, 50};  vecs[0].bi = '{1, 1, 1, 1, 1};
    vecs[0].relu = 1'b0;                  vecs[0].e  = '{11, -19, 31, -39, 51};
    vecs[1].b = '{10, -20, 30, -40, 50};  vecs[1].bi = '{1, 1, 1, 1, 1};
    vecs[1].relu = 1'b1;                  vecs[1].e  = '{11, 0, 31, 0, 51};
    vecs[2].b = '{32760, -32760, 0, -1, 100};  vecs[2].bi = '{100, -100, 0, 0, -200};
    vecs[2].relu = 1'b0;                  vecs[2].e  = '{32767, -32768, 0, -1, -100};
    vecs[3].b = '{32760, -32760, 0, -1, 100};  vecs[3].bi = '{100, -100, 0, 0, -200};
    vecs[3].relu = 1'b1;                  vecs[3].e  = '{32767, 0, 0, 0, 0};
    vecs[4].b = '{1, 2, 3, 4, 5};         vecs[4].bi = '{0, 0, 0, 0, 0};
    vecs[4].relu = 1'b0;                  vecs[4].e  = '{1, 2, 3, 4, 5};

    reset     = 1'b0;
    b_in      = '0;
    bias      = '0;
    b_valid   = 1'b0;
    relu_en   = 1'b0;
    m_tready  = 1'b0;
    b_in1     = '0;
    bias1     = '0;
    b_valid1  = 1'b0;
    m_tready1 = 1'b1;

    // Reset held for 3 cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst b_ready", int'(b_ready), 0);
      chk("rst tvalid", int'(m_tvalid), 0);
      chk("rst tlast", int'(m_tlast), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst tdata", int'(m_tdata), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    expect_idle("post-reset");
    m_tready = 1'b1;
    @(negedge clk);
    expect_idle("tready in idle");

    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t], $sformatf("vec%0d", t));
    end

    // Single-row instance: first beat is also the last.
    @(negedge clk);
    b_in1[0][0]  = 16'd7;
    bias1[0][0]  = 16'hfffd;
    b_valid1     = 1'b1;
    @(negedge clk);
    b_valid1 = 1'b0;
    chk("m1 tvalid", int'(m_tvalid1), 1);
    chk("m1 tdata", int'($signed(m_tdata1)), 4);
    chk("m1 tlast", int'(m_tlast1), 1);
    @(negedge clk);
    chk("m1 idle tvalid", int'(m_tvalid1), 0);
    chk("m1 idle b_ready", int'(b_ready1), 1);

    // Backpressure at beat 2 with b_valid pulses ignored during SEND.
    @(negedge clk);
    drive_vec(vecs[0]);
    b_valid  = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    expect_beat("bp beat0", 11, 1'b0);
    @(negedge clk);
    expect_beat("bp beat1", -19, 1'b0);
    @(negedge clk);
    expect_beat("bp beat2", 31, 1'b0);
    m_tready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      expect_beat($sformatf("bp stall%0d", s), 31, 1'b0);
      if (s == 0) begin
        drive_vec(vecs[2]);
        b_valid = 1'b1;
      end else begin
        b_valid = 1'b0;
      end
      if (s == 2) m_tready = 1'b1;
    end
    @(negedge clk);
    expect_beat("bp beat3", -39, 1'b0);
    @(negedge clk);
    expect_beat("bp beat4", 51, 1'b1);
    @(negedge clk);
    expect_idle("bp end");
    @(negedge clk);
    expect_idle("bp no extra capture");

    // b_valid held high: one stream, then exactly one recapture on the first idle cycle.
    drive_vec(vecs[4]);
    b_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      expect_beat($sformatf("hold beat%0d", k), k + 1, k == 4);
      @(negedge clk);
    end
    expect_idle("hold gap");
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_beat($sformatf("hold2 beat%0d", k), k + 1, k == 4);
      @(negedge clk);
    end
    expect_idle("hold2 end");
    @(negedge clk);
    expect_idle("hold2 quiet");

    // Reset after two beats: vector abandoned, no partial resend.
    drive_vec(vecs[0]);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    expect_beat("mid beat0", 11, 1'b0);
    @(negedge clk);
    expect_beat("mid beat1", -19, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid rst tvalid", int'(m_tvalid), 0);
    chk("mid rst b_ready", int'(b_ready), 0);
    chk("mid rst tdata", int'(m_tdata), 0);
    chk("mid rst busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("mid after release");
    run_vec(vecs[4], "after-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
